// File: rtl/pipe_hazard_sequencer.sv
// Pipeline hazard controller: forwarding selects, load-use bubbles, dmem wait freeze,
// and ecall/mret drain + redirect sequencing for the 5-stage core.
//
//   state            | meaning
//   ST_RUN           | normal issue; branch flush / load-use bubble handled in-cycle
//   ST_MEM_WAIT      | data access outstanding, front end and decode frozen
//   ST_TRAP_DRAIN    | flushing front end after ecall/mret seen in EX
//   ST_TRAP_REDIRECT | one-cycle PC redirect to trap vector or mepc
module pipe_hazard_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_regwrite,
  input  logic             ex_is_load,
  input  logic [4:0]       mem_wreg,
  input  logic             mem_regwrite,
  input  logic             ex_branch_taken,
  input  logic             ex_ecall,
  input  logic             ex_mret,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             flush_if,
  output logic             keep_id,
  output logic             nop_id,
  output logic [1:0]       fwd_rs1,
  output logic [1:0]       fwd_rs2,
  output logic             trap_redirect,
  output logic             trap_is_mret,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_TRAP_DRAIN,
    ST_TRAP_REDIRECT
  } state_t;

  localparam logic [3:0]  DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
  localparam logic [15:0] WAIT_LIMIT = 16'(MEM_TIMEOUT);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_drain_cnt, w_drain_nxt;
  logic [15:0]      r_wait_cnt, w_wait_nxt;
  logic             r_is_mret, w_is_mret_nxt;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_stall, w_flush, w_keep, w_nop, w_redir;
  logic [1:0] w_fwd_rs1, w_fwd_rs2;
  logic       w_load_use, w_mem_stall;

  always_comb begin
    w_fwd_rs1 = 2'b00;
    if (id_use_rs1 && id_rs1 != 5'd0) begin
      if (ex_regwrite && !ex_is_load && ex_wreg == id_rs1)
        w_fwd_rs1 = 2'b01;
      else if (mem_regwrite && mem_wreg == id_rs1)
        w_fwd_rs1 = 2'b10;
    end
  end

  always_comb begin
    w_fwd_rs2 = 2'b00;
    if (id_use_rs2 && id_rs2 != 5'd0) begin
      if (ex_regwrite && !ex_is_load && ex_wreg == id_rs2)
        w_fwd_rs2 = 2'b01;
      else if (mem_regwrite && mem_wreg == id_rs2)
        w_fwd_rs2 = 2'b10;
    end
  end

  assign w_load_use = ex_is_load && ex_regwrite && (ex_wreg != 5'd0) &&
                      ((id_use_rs1 && ex_wreg == id_rs1) ||
                       (id_use_rs2 && ex_wreg == id_rs2));
  assign w_mem_stall = dmem_req && !dmem_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_drain_nxt   = r_drain_cnt;
    w_wait_nxt    = r_wait_cnt;
    w_is_mret_nxt = r_is_mret;
    w_err_nxt     = r_err;
    w_stall       = 1'b0;
    w_flush       = 1'b0;
    w_keep        = 1'b0;
    w_nop         = 1'b0;
    w_redir       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) begin
          w_stall     = 1'b1;
          w_keep      = 1'b1;
          w_wait_nxt  = 16'd1;
          w_state_nxt = ST_MEM_WAIT;
        end else if (ex_ecall || ex_mret) begin
          w_stall       = 1'b1;
          w_flush       = 1'b1;
          w_nop         = 1'b1;
          w_is_mret_nxt = ex_mret;
          w_drain_nxt   = DRAIN_INIT;
          w_state_nxt   = (DRAIN_CYCLES == 1) ? ST_TRAP_REDIRECT : ST_TRAP_DRAIN;
        end else if (ex_branch_taken) begin
          // the taken branch squashes the ID instruction, so any load-use on it is moot
          w_flush = 1'b1;
          w_nop   = 1'b1;
        end else if (w_load_use) begin
          w_stall = 1'b1;
          w_nop   = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_stall = 1'b1;
          w_keep  = 1'b1;
          if (r_wait_cnt >= WAIT_LIMIT) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_wait_nxt = r_wait_cnt + 16'd1;
          end
        end
      end
      ST_TRAP_DRAIN: begin
        w_stall = 1'b1;
        w_flush = 1'b1;
        w_nop   = 1'b1;
        // an outstanding data access stretches the drain instead of freezing it
        if (!w_mem_stall) begin
          if (r_drain_cnt <= 4'd1) begin
            w_drain_nxt = 4'd0;
            w_state_nxt = ST_TRAP_REDIRECT;
          end else begin
            w_drain_nxt = r_drain_cnt - 4'd1;
          end
        end
      end
      ST_TRAP_REDIRECT: begin
        w_redir     = 1'b1;
        w_flush     = 1'b1;
        w_nop       = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= 4'd0;
      r_wait_cnt  <= 16'd0;
      r_is_mret   <= 1'b0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_is_mret   <= w_is_mret_nxt;
      r_err       <= w_err_nxt;
      if (w_stall && r_stall_cnt != {CNT_W{1'b1}})
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // controls are forced quiet while reset is held, whatever the inputs do
  assign stall_if        = rst & w_stall;
  assign flush_if        = rst & w_flush;
  assign keep_id         = rst & w_keep;
  assign nop_id          = rst & w_nop;
  assign trap_redirect   = rst & w_redir;
  assign fwd_rs1         = rst ? w_fwd_rs1 : 2'b00;
  assign fwd_rs2         = rst ? w_fwd_rs2 : 2'b00;
  assign trap_is_mret    = r_is_mret;
  assign mem_timeout_err = r_err;
  assign stall_cnt       = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Bench for pipe_hazard_sequencer: per-cycle expected controls queued with stimulus,
// compared mid-cycle. Second instance covers timeout, counter saturation and 1-cycle drain.
module tb_pipe_hazard_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [4:0] id_rs1, id_rs2, ex_wreg, mem_wreg;
  logic       id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load, mem_regwrite;
  logic       ex_branch_taken, ex_ecall, ex_mret, dmem_req, dmem_ready;
  logic       stall_if, flush_if, keep_id, nop_id, trap_redirect, trap_is_mret, mem_timeout_err;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic [15:0] stall_cnt;

  logic       t_dmem_req, t_dmem_ready, t_ex_ecall;
  logic [4:0] t_z5;
  logic       t_z;
  logic       t_stall_if, t_flush_if, t_keep_id, t_nop_id, t_trap_redirect, t_trap_is_mret, t_err;
  logic [1:0] t_fwd_rs1, t_fwd_rs2;
  logic [2:0] t_stall_cnt;

  assign t_z5 = 5'd0;
  assign t_z  = 1'b0;

  pipe_hazard_sequencer #(.DRAIN_CYCLES(2), .MEM_TIMEOUT(255), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
    .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite),
    .ex_branch_taken(ex_branch_taken), .ex_ecall(ex_ecall), .ex_mret(ex_mret),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_if(stall_if), .flush_if(flush_if), .keep_id(keep_id), .nop_id(nop_id),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .trap_redirect(trap_redirect), .trap_is_mret(trap_is_mret),
    .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt)
  );

  pipe_hazard_sequencer #(.DRAIN_CYCLES(1), .MEM_TIMEOUT(3), .CNT_W(3)) dut_t (
    .clk(clk), .rst(rst),
    .id_rs1(t_z5), .id_rs2(t_z5), .id_use_rs1(t_z), .id_use_rs2(t_z),
    .ex_wreg(t_z5), .ex_regwrite(t_z), .ex_is_load(t_z),
    .mem_wreg(t_z5), .mem_regwrite(t_z),
    .ex_branch_taken(t_z), .ex_ecall(t_ex_ecall), .ex_mret(t_z),
    .dmem_req(t_dmem_req), .dmem_ready(t_dmem_ready),
    .stall_if(t_stall_if), .flush_if(t_flush_if), .keep_id(t_keep_id), .nop_id(t_nop_id),
    .fwd_rs1(t_fwd_rs1), .fwd_rs2(t_fwd_rs2),
    .trap_redirect(t_trap_redirect), .trap_is_mret(t_trap_is_mret),
    .mem_timeout_err(t_err), .stall_cnt(t_stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [10:0] q_ctl[$];
  logic [15:0] q_cnt[$];
  logic [10:0] q_t_ctl[$];
  logic [15:0] q_t_cnt[$];

  logic [10:0] w_ctl, w_t_ctl;
  assign w_ctl   = {stall_if, flush_if, keep_id, nop_id, fwd_rs1, fwd_rs2,
                    trap_redirect, trap_is_mret, mem_timeout_err};
  assign w_t_ctl = {t_stall_if, t_flush_if, t_keep_id, t_nop_id, t_fwd_rs1, t_fwd_rs2,
                    t_trap_redirect, t_trap_is_mret, t_err};

  // ctl packing: {stall, flush, keep, nop, fwd1, fwd2, redirect, is_mret, timeout_err}
  function automatic logic [10:0] mk(input bit s, input bit f, input bit k, input bit n,
                                      input logic [1:0] f1, input logic [1:0] f2,
                                      input bit r, input bit m, input bit e);
    return {s, f, k, n, f1, f2, r, m, e};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_m(input logic [10:0] ctl, input logic [15:0] cnt);
    q_ctl.push_back(ctl);
    q_cnt.push_back(cnt);
  endtask

  task automatic exp_t(input logic [10:0] ctl, input logic [15:0] cnt);
    q_t_ctl.push_back(ctl);
    q_t_cnt.push_back(cnt);
  endtask

  task automatic settle(input string tag);
    logic [10:0] c;
    logic [15:0] k;
    @(negedge clk);
    while (q_ctl.size() > 0) begin
      c = q_ctl.pop_front();
      k = q_cnt.pop_front();
      check_val({tag, "/ctl"}, w_ctl, c);
      check_val({tag, "/cnt"}, stall_cnt, k);
    end
    while (q_t_ctl.size() > 0) begin
      c = q_t_ctl.pop_front();
      k = q_t_cnt.pop_front();
      check_val({tag, "/t_ctl"}, w_t_ctl, c);
      check_val({tag, "/t_cnt"}, {13'd0, t_stall_cnt}, k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_wreg = 5'd0; ex_regwrite = 1'b0; ex_is_load = 1'b0;
    mem_wreg = 5'd0; mem_regwrite = 1'b0;
    ex_branch_taken = 1'b0; ex_ecall = 1'b0; ex_mret = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
    t_dmem_req = 1'b0; t_dmem_ready = 1'b0; t_ex_ecall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] z;
    z = mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // reset with hazards, a trap and a forwarding match all presented
    clr_in();
    rst = 1'b0;
    ex_branch_taken = 1'b1; ex_ecall = 1'b1; dmem_req = 1'b1;
    ex_wreg = 5'd3; ex_regwrite = 1'b1; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    t_dmem_req = 1'b1; t_ex_ecall = 1'b1;
    exp_m(z, 16'd0);
    exp_t(z, 16'd0);
    settle("reset");
    clr_in();
    rst = 1'b1;

    // lw x5 in EX, add x6,x5,x1 in ID
    ex_wreg = 5'd5; ex_regwrite = 1'b1; ex_is_load = 1'b1;
    id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd1; id_use_rs2 = 1'b1;
    exp_m(mk(1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0), 16'd0);
    settle("lu_stall");
    clr_in();
    mem_wreg = 5'd5; mem_regwrite = 1'b1;
    id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd1; id_use_rs2 = 1'b1;
    exp_m(mk(0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0), 16'd1);
    settle("lu_fwd");

    // EX beats MEM, rs2=x0 never forwarded
    clr_in();
    ex_wreg = 5'd3; ex_regwrite = 1'b1; mem_wreg = 5'd3; mem_regwrite = 1'b1;
    id_rs1 = 5'd3; id_use_rs1 = 1'b1; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    exp_m(mk(0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0), 16'd1);
    settle("fwd_ex");
    clr_in();
    ex_wreg = 5'd0; ex_regwrite = 1'b1; mem_wreg = 5'd0; mem_regwrite = 1'b1;
    id_rs1 = 5'd0; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    exp_m(z, 16'd1);
    settle("fwd_x0");
    clr_in();
    ex_wreg = 5'd4; ex_regwrite = 1'b1; id_rs1 = 5'd4; id_use_rs1 = 1'b0;
    mem_wreg = 5'd7; mem_regwrite = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    exp_m(mk(0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0), 16'd1);
    settle("fwd_mem");

    // taken branch with a coincident load-use: flush only, no stall
    clr_in();
    ex_branch_taken = 1'b1; ex_is_load = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd9;
    id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    exp_m(mk(0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0), 16'd1);
    settle("br_lu");
    clr_in();
    exp_m(z, 16'd1);
    settle("br_after");

    // dmem wait: ready low 4 cycles, branch ignored mid-wait
    for (int i = 0; i < 4; i++) begin
      clr_in();
      dmem_req = 1'b1;
      ex_branch_taken = (i == 2);
      exp_m(mk(1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0), 16'(1 + i));
      settle("mem_wait");
    end
    clr_in();
    dmem_req = 1'b1; dmem_ready = 1'b1;
    exp_m(z, 16'd5);
    settle("mem_rdy");
    clr_in();
    exp_m(z, 16'd5);
    settle("mem_idle");

    // mret, 2-cycle drain then redirect
    clr_in();
    ex_mret = 1'b1;
    exp_m(mk(1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0), 16'd5);
    settle("mret_see");
    clr_in();
    exp_m(mk(1, 1, 0, 1, 2'b00, 2'b00, 0, 1, 0), 16'd6);
    settle("mret_drain");
    exp_m(mk(0, 1, 0, 1, 2'b00, 2'b00, 1, 1, 0), 16'd7);
    settle("mret_redir");
    exp_m(mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0), 16'd7);
    settle("mret_done");

    // ecall with a dmem hold stretching the drain
    ex_ecall = 1'b1;
    exp_m(mk(1, 1, 0, 1, 2'b00, 2'b00, 0, 1, 0), 16'd7);
    settle("ecall_see");
    clr_in();
    dmem_req = 1'b1;
    exp_m(mk(1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0), 16'd8);
    settle("ecall_hold");
    clr_in();
    exp_m(mk(1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0), 16'd9);
    settle("ecall_drain");
    exp_m(mk(0, 1, 0, 1, 2'b00, 2'b00, 1, 0, 0), 16'd10);
    settle("ecall_redir");
    exp_m(z, 16'd10);
    settle("ecall_done");

    // reset mid-drain: everything quiet at once, no redirect afterwards
    ex_ecall = 1'b1;
    exp_m(mk(1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0), 16'd10);
    settle("rd_see");
    clr_in();
    rst = 1'b0;
    ex_ecall = 1'b1; ex_branch_taken = 1'b1;
    exp_m(z, 16'd0);
    settle("rd_rst");
    clr_in();
    rst = 1'b1;

    // second instance: timeout at 3 wait cycles, 3-bit counter saturation, 1-cycle drain
    for (int i = 0; i < 4; i++) begin
      clr_in();
      t_dmem_req = 1'b1;
      exp_m(z, 16'd0);
      exp_t(mk(1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0), 16'(i));
      settle("to_wait");
    end
    clr_in();
    exp_m(z, 16'd0);
    exp_t(mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1), 16'd4);
    settle("to_err");
    for (int i = 0; i < 6; i++) begin
      clr_in();
      t_dmem_req = 1'b1;
      exp_m(z, 16'd0);
      exp_t(mk(1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1), (i < 3) ? 16'(4 + i) : 16'd7);
      settle("sat");
    end
    clr_in();
    t_dmem_req = 1'b1; t_dmem_ready = 1'b1;
    exp_m(z, 16'd0);
    exp_t(mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1), 16'd7);
    settle("sat_rdy");
    clr_in();
    exp_m(z, 16'd0);
    exp_t(mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1), 16'd7);
    settle("sat_idle");
    t_ex_ecall = 1'b1;
    exp_m(z, 16'd0);
    exp_t(mk(1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 1), 16'd7);
    settle("d1_see");
    clr_in();
    exp_m(z, 16'd0);
    exp_t(mk(0, 1, 0, 1, 2'b00, 2'b00, 1, 0, 1), 16'd7);
    settle("d1_redir");
    exp_m(z, 16'd0);
    exp_t(mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1), 16'd7);
    settle("d1_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
